// File: rtl/signal_gen_frame.sv
// Frame-based complex waveform generator: fills a 2**N-sample buffer one pair
// per cycle, then presents the whole frame until the consumer accepts it.
module signal_gen_frame #(
  parameter int N   = 3,
  parameter int W   = 8,
  parameter int AMP = 63
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [2:0]           regime,
  input  logic                 sweep,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [(2**N)*W-1:0]  out_r,
  output logic [(2**N)*W-1:0]  out_i,
  output logic [15:0]          frame_cnt
);

  localparam int L = 2**N;
  localparam logic [W-1:0] A  = W'(AMP);
  localparam logic [W-1:0] NA = W'(-AMP);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FILL = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [N-1:0]          idx_q, idx_d;
  logic [N-1:0]          ph_q, ph_d;
  logic [15:0]           lfsr_q, lfsr_d;
  logic [2:0]            reg_q, reg_d;
  logic                  swp_q, swp_d;
  logic                  vld_q, vld_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [L-1:0][W-1:0]   buf_r_q, buf_r_d, buf_i_q, buf_i_d;
  logic [L-1:0][W-1:0]   out_r_q, out_r_d, out_i_q, out_i_d;

  logic [N-1:0]          p;
  logic [1:0]            p4;
  logic [W-1:0]          smp_a, smp_r, smp_i, lfsr_sh;
  logic                  swap;
  logic [15:0]           lfsr_step;

  assign lfsr_step = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign lfsr_sh   = W'($signed(lfsr_q[W-1:0]) >>> 1);

  // Waveform for the sample being written this cycle; odd regimes (except
  // the impulse) route it to the imaginary rail instead of the real one.
  always_comb begin
    p     = idx_q + ph_q;
    p4    = 2'(p);
    smp_a = '0;
    case (reg_q)
      3'b000, 3'b001: smp_a = p4[1] ? NA : A;
      3'b010, 3'b011: smp_a = p4[0] ? A : NA;
      3'b100, 3'b101: smp_a = (p4 == 2'd0) ? A : ((p4 == 2'd2) ? NA : '0);
      3'b110:         smp_a = lfsr_sh;
      default:        smp_a = (idx_q == ph_q) ? A : '0;
    endcase
    swap  = reg_q[0] && (reg_q != 3'b111);
    smp_r = swap ? '0 : smp_a;
    smp_i = swap ? smp_a : '0;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ph_d    = ph_q;
    lfsr_d  = lfsr_q;
    reg_d   = reg_q;
    swp_d   = swp_q;
    vld_d   = vld_q;
    cnt_d   = cnt_q;
    buf_r_d = buf_r_q;
    buf_i_d = buf_i_q;
    out_r_d = out_r_q;
    out_i_d = out_i_q;
    case (state_q)
      IDLE: begin
        if (en) begin
          state_d = FILL;
          idx_d   = '0;
          reg_d   = regime;
          swp_d   = sweep;
        end
      end
      FILL: begin
        buf_r_d[idx_q] = smp_r;
        buf_i_d[idx_q] = smp_i;
        if (reg_q == 3'b110) lfsr_d = lfsr_step;
        if (idx_q == N'(L-1)) begin
          // copy includes the sample written on this same edge
          state_d = HOLD;
          out_r_d = buf_r_d;
          out_i_d = buf_i_d;
          vld_d   = 1'b1;
        end else begin
          idx_d = idx_q + N'(1);
        end
      end
      HOLD: begin
        if (vld_q && out_ready) begin
          vld_d = 1'b0;
          cnt_d = cnt_q + 16'd1;
          if (swp_q) ph_d = ph_q + N'(1);
          if (en) begin
            state_d = FILL;
            idx_d   = '0;
            reg_d   = regime;
            swp_d   = sweep;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ph_q    <= '0;
      lfsr_q  <= 16'hACE1;
      reg_q   <= '0;
      swp_q   <= 1'b0;
      vld_q   <= 1'b0;
      cnt_q   <= '0;
      buf_r_q <= '0;
      buf_i_q <= '0;
      out_r_q <= '0;
      out_i_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ph_q    <= ph_d;
      lfsr_q  <= lfsr_d;
      reg_q   <= reg_d;
      swp_q   <= swp_d;
      vld_q   <= vld_d;
      cnt_q   <= cnt_d;
      buf_r_q <= buf_r_d;
      buf_i_q <= buf_i_d;
      out_r_q <= out_r_d;
      out_i_q <= out_i_d;
    end
  end

  assign out_valid = vld_q;
  assign out_r     = out_r_q;
  assign out_i     = out_i_q;
  assign frame_cnt = cnt_q;

endmodule

// File: tb/tb_signal_gen_frame.sv
// Directed bench for signal_gen_frame at N=3, W=8, AMP=63.
module tb_signal_gen_frame;

  logic        clk = 1'b0;
  logic        rst, en, sweep, out_ready;
  logic [2:0]  regime;
  logic        out_valid;
  logic [63:0] out_r, out_i;
  logic [15:0] frame_cnt;

  int checks   = 0;
  int failures = 0;

  signal_gen_frame #(.N(3), .W(8), .AMP(63)) dut (
    .clk(clk), .rst(rst), .en(en), .regime(regime), .sweep(sweep),
    .out_ready(out_ready), .out_valid(out_valid), .out_r(out_r),
    .out_i(out_i), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; regime = 3'd0; sweep = 1'b0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic wait_valid(input string nm);
    int n;
    n = 0;
    while (!out_valid && n < 40) begin tick(); n++; end
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL %s timeout: out_valid=%b, want 1", nm, out_valid);
    end
  endtask

  task automatic accept(input logic keep_en);
    en = keep_en; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({out_valid, out_r, out_i, frame_cnt} !== '0) begin
      failures++;
      $display("FAIL reset: valid=%b r=%h i=%h cnt=%0d, want all 0", out_valid, out_r, out_i, frame_cnt);
    end
  endtask

  task automatic test_latency();
    do_reset();
    en = 1'b1; regime = 3'b000;
    for (int c = 1; c <= 8; c++) tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL latency_early: valid=%b at cycle 8, want 0", out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1) begin
      failures++; $display("FAIL latency: valid=%b at cycle 9, want 1", out_valid);
    end
    checks++;
    if (out_r !== 64'hC1C13F3FC1C13F3F || out_i !== 64'h0) begin
      failures++; $display("FAIL regime0_data: r=%h i=%h, want C1C13F3FC1C13F3F / 0", out_r, out_i);
    end
  endtask

  // Runs right after test_latency: frame is held in HOLD with out_ready low.
  task automatic test_hold_stable();
    for (int c = 0; c < 20; c++) begin
      regime = regime + 3'd1; sweep = ~sweep;
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_r !== 64'hC1C13F3FC1C13F3F || out_i !== 64'h0 || frame_cnt !== 16'd0) begin
        failures++;
        $display("FAIL hold_stable c=%0d: valid=%b r=%h i=%h cnt=%0d", c, out_valid, out_r, out_i, frame_cnt);
      end
    end
    accept(1'b0);
    checks++;
    if (out_valid !== 1'b0 || frame_cnt !== 16'd1 || out_r !== 64'hC1C13F3FC1C13F3F) begin
      failures++;
      $display("FAIL handshake: valid=%b cnt=%0d r=%h, want 0/1/C1C13F3FC1C13F3F", out_valid, frame_cnt, out_r);
    end
    tick(); tick();
    checks++;
    if (out_valid !== 1'b0 || out_r !== 64'hC1C13F3FC1C13F3F) begin
      failures++; $display("FAIL idle_keep: valid=%b r=%h, want 0/C1C13F3FC1C13F3F", out_valid, out_r);
    end
  endtask

  task automatic test_regimes();
    logic [2:0]  rg  [4] = '{3'b001, 3'b010, 3'b011, 3'b101};
    logic [63:0] er  [4] = '{64'h0, 64'h3FC13FC13FC13FC1, 64'h0, 64'h0};
    logic [63:0] ei  [4] = '{64'hC1C13F3FC1C13F3F, 64'h0, 64'h3FC13FC13FC13FC1, 64'h00C1003F00C1003F};
    for (int t = 0; t < 4; t++) begin
      do_reset();
      en = 1'b1; regime = rg[t];
      wait_valid("regime");
      checks++;
      if (out_r !== er[t] || out_i !== ei[t]) begin
        failures++;
        $display("FAIL regime%b: r=%h i=%h, want %h / %h", rg[t], out_r, out_i, er[t], ei[t]);
      end
    end
  endtask

  task automatic test_sweep();
    logic [63:0] ex [3] = '{64'h00C1003F00C1003F, 64'h3F00C1003F00C100, 64'h003F00C1003F00C1};
    do_reset();
    en = 1'b1; regime = 3'b100; sweep = 1'b1;
    for (int f = 0; f < 3; f++) begin
      wait_valid("sweep");
      checks++;
      if (out_r !== ex[f] || out_i !== 64'h0) begin
        failures++; $display("FAIL sweep f=%0d: r=%h i=%h, want %h / 0", f, out_r, out_i, ex[f]);
      end
      accept(1'b1);
    end
    checks++;
    if (frame_cnt !== 16'd3) begin
      failures++; $display("FAIL sweep_cnt: cnt=%0d, want 3", frame_cnt);
    end
  endtask

  task automatic test_impulse();
    logic [63:0] e;
    do_reset();
    en = 1'b1; regime = 3'b111; sweep = 1'b1;
    for (int f = 0; f < 9; f++) begin
      wait_valid("impulse");
      e = 64'h3F << (8 * (f % 8));
      checks++;
      if (out_r !== e || out_i !== 64'h0) begin
        failures++; $display("FAIL impulse f=%0d: r=%h i=%h, want %h / 0", f, out_r, out_i, e);
      end
      accept(f < 8);
    end
    checks++;
    if (frame_cnt !== 16'd9) begin
      failures++; $display("FAIL impulse_cnt: cnt=%0d, want 9", frame_cnt);
    end
  endtask

  task automatic test_lfsr();
    logic [15:0] l;
    logic [7:0]  e;
    do_reset();
    en = 1'b1; regime = 3'b110;
    wait_valid("lfsr");
    checks++;
    if (out_r[7:0] !== 8'hF0) begin
      failures++; $display("FAIL lfsr_first: got %h, want F0", out_r[7:0]);
    end
    l = 16'hACE1;
    for (int k = 0; k < 8; k++) begin
      e = {l[7], l[7:1]};
      l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
      checks++;
      if (out_r[k*8 +: 8] !== e) begin
        failures++; $display("FAIL lfsr k=%0d: got %h, want %h", k, out_r[k*8 +: 8], e);
      end
    end
    checks++;
    if (out_i !== 64'h0) begin
      failures++; $display("FAIL lfsr_imag: got %h, want 0", out_i);
    end
  endtask

  task automatic test_reset_mid_fill();
    do_reset();
    en = 1'b1; regime = 3'b000;
    wait_valid("mid_first");
    accept(1'b1);
    for (int c = 0; c < 4; c++) tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({out_valid, out_r, out_i, frame_cnt} !== '0) begin
      failures++;
      $display("FAIL mid_reset: valid=%b r=%h i=%h cnt=%0d, want all 0", out_valid, out_r, out_i, frame_cnt);
    end
    rst = 1'b0;
    for (int c = 1; c <= 8; c++) tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL mid_relat_early: valid=%b, want 0", out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_r !== 64'hC1C13F3FC1C13F3F) begin
      failures++; $display("FAIL mid_relat: valid=%b r=%h, want 1 / C1C13F3FC1C13F3F", out_valid, out_r);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_hold_stable();
    test_regimes();
    test_sweep();
    test_impulse();
    test_lfsr();
    test_reset_mid_fill();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
